control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 179 +++++++++++++++++
 tb/tb_control_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle MIPS-subset control FSM with registered Moore outputs.
// Define CONTROL_UNIT_OVF_EXC_EN to send add/sub/addi overflow to the EXC state.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       epc_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [4:0] state_out
);

  // state      | meaning
  // RST        | write 227 to $29
  // FETCH      | PC <= PC + 4
  // FETCH_WAIT | load IR
  // DECODE     | branch target into ALUOut, dispatch on opcode
  // EXEC_R     | R-type ALU op
  // WB_R       | write rd
  // EXEC_I     | addi ALU op
  // WB_I       | write rt
  // MEM_ADDR   | compute load/store address
  // MEM_RD     | read issue
  // MEM_WAIT   | read latency
  // WB_LW      | write MDR to rt
  // MEM_WRITE  | store strobe
  // BRANCH     | compare and conditionally take branch
  // JUMP       | jump
  // JAL        | jump and link $31
  // JR         | jump to register A
  // EXC        | overflow exception, EPC capture
  typedef enum logic [4:0] {
    RST = 5'd0, FETCH = 5'd1, FETCH_WAIT = 5'd2, DECODE = 5'd3,
    EXEC_R = 5'd4, WB_R = 5'd5, EXEC_I = 5'd6, WB_I = 5'd7,
    MEM_ADDR = 5'd8, MEM_RD = 5'd9, MEM_WAIT = 5'd10, WB_LW = 5'd11,
    MEM_WRITE = 5'd12, BRANCH = 5'd13, JUMP = 5'd14, JAL = 5'd15,
    JR = 5'd16, EXC = 5'd17
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       epc_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;

  state_t state, state_nx;
  ctrl_t  ctrl;

  function automatic ctrl_t decode(input state_t st, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      RST:        begin c.reg_wr = 1'b1; c.reg_dst = 2'b01; c.mem_to_reg = 2'b11; end
      FETCH:      begin c.alu_src_b = 2'b01; c.alu_op = 3'b001; c.pc_write = 1'b1; end
      FETCH_WAIT: c.ir_wr = 1'b1;
      DECODE:     begin c.alu_src_b = 2'b11; c.alu_op = 3'b001; end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        case (fn)
          FN_ADD:  c.alu_op = 3'b001;
          FN_SUB:  c.alu_op = 3'b010;
          FN_AND:  c.alu_op = 3'b011;
          default: c.alu_op = 3'b000;
        endcase
      end
      WB_R:       begin c.reg_wr = 1'b1; c.reg_dst = 2'b11; end
      EXEC_I, MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b001; end
      WB_I:       c.reg_wr = 1'b1;
      WB_LW:      begin c.reg_wr = 1'b1; c.mem_to_reg = 2'b01; end
      MEM_WRITE:  c.mem_wr = 1'b1;
      // pc_write for BRANCH is resolved combinationally from zero below
      BRANCH:     begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; c.pc_source = 2'b01; end
      JUMP:       begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      JAL: begin
        c.reg_wr = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        c.pc_source = 2'b10; c.pc_write = 1'b1;
      end
      JR:         begin c.alu_src_a = 1'b1; c.pc_write = 1'b1; end
`ifdef CONTROL_UNIT_OVF_EXC_EN
      EXC:        begin c.epc_wr = 1'b1; c.pc_source = 2'b11; c.pc_write = 1'b1; end
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nx = FETCH;
    case (state)
      RST:        state_nx = FETCH;
      FETCH:      state_nx = FETCH_WAIT;
      FETCH_WAIT: state_nx = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR) state_nx = JR;
            else if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) state_nx = EXEC_R;
            else state_nx = FETCH;
          end
          OP_ADDI:       state_nx = EXEC_I;
          OP_LW, OP_SW:  state_nx = MEM_ADDR;
          OP_BEQ, OP_BNE: state_nx = BRANCH;
          OP_J:          state_nx = JUMP;
          OP_JAL:        state_nx = JAL;
          default:       state_nx = FETCH;
        endcase
      end
      EXEC_R: begin
        state_nx = WB_R;
`ifdef CONTROL_UNIT_OVF_EXC_EN
        if (overflow && (funct == FN_ADD || funct == FN_SUB)) state_nx = EXC;
`endif
      end
      EXEC_I: begin
        state_nx = WB_I;
`ifdef CONTROL_UNIT_OVF_EXC_EN
        if (overflow) state_nx = EXC;
`endif
      end
      MEM_ADDR: state_nx = (opcode == OP_LW) ? MEM_RD : MEM_WRITE;
      MEM_RD:   state_nx = MEM_WAIT;
      MEM_WAIT: state_nx = WB_LW;
      default:  state_nx = FETCH;
    endcase
    if (reset) state_nx = RST;
  end

  // outputs are decoded from the upcoming state so they line up with state
  always_ff @(posedge clk) begin
    state <= state_nx;
    ctrl  <= decode(state_nx, funct);
  end

  assign pc_write   = ctrl.pc_write |
                      ((state == BRANCH) && ((opcode == OP_BNE) ? !zero : zero));
  assign mem_wr     = ctrl.mem_wr;
  assign ir_wr      = ctrl.ir_wr;
  assign reg_wr     = ctrl.reg_wr;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign state_out  = state;

`ifdef CONTROL_UNIT_OVF_EXC_EN
  assign epc_wr = ctrl.epc_wr;
`else
  logic unused_bits;
  assign unused_bits = ^{overflow, ctrl.epc_wr};
  assign epc_wr = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the control_unit state sequencing and decode.
// Build with CONTROL_UNIT_OVF_EXC_EN to exercise the overflow exception path.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       pc_write, mem_wr, ir_wr, reg_wr, epc_wr, alu_src_a;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [4:0] state_out;

  int checks = 0;
  int errs   = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .pc_write(pc_write), .mem_wr(mem_wr), .ir_wr(ir_wr),
    .reg_wr(reg_wr), .epc_wr(epc_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves the FSM sitting in RST with reset released
  task automatic do_reset(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; zero = 1'b0; overflow = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(6'h3F, 6'h00);
    checks++;
    if (state_out !== 5'd0 || {reg_wr, reg_dst, mem_to_reg} !== 5'b1_01_11 || pc_write !== 1'b0) begin
      errs++;
      $display("FAIL reset_decode: state=%0d wr/dst/m2r=%b pcw=%b, want 0 10111 0",
               state_out, {reg_wr, reg_dst, mem_to_reg}, pc_write);
    end
    step();
    checks++;
    if (state_out !== 5'd1 || {pc_write, alu_src_a, alu_src_b, alu_op, pc_source} !== 9'b1_0_01_001_00) begin
      errs++;
      $display("FAIL fetch_decode: state=%0d ctl=%b, want 1 100100100",
               state_out, {pc_write, alu_src_a, alu_src_b, alu_op, pc_source});
    end
    step();
    checks++;
    if (state_out !== 5'd2 || ir_wr !== 1'b1) begin
      errs++;
      $display("FAIL fetch_wait: state=%0d ir_wr=%b, want 2 1", state_out, ir_wr);
    end
    step();
    checks++;
    if (state_out !== 5'd3 || {alu_src_a, alu_src_b, alu_op} !== 6'b0_11_001 || ir_wr !== 1'b0) begin
      errs++;
      $display("FAIL decode_state: state=%0d srca/srcb/op=%b ir_wr=%b, want 3 011001 0",
               state_out, {alu_src_a, alu_src_b, alu_op}, ir_wr);
    end
  endtask

  task automatic test_rtype_sub();
    int exp_st[6];
    exp_st = '{1, 2, 3, 4, 5, 1};
    do_reset(6'h00, 6'h22);
    foreach (exp_st[i]) begin
      step();
      checks++;
      if (state_out !== exp_st[i][4:0]) begin
        errs++;
        $display("FAIL sub_seq[%0d]: state=%0d want %0d", i, state_out, exp_st[i]);
      end
      if (exp_st[i] == 4) begin
        checks++;
        if (alu_op !== 3'b010 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
          errs++;
          $display("FAIL sub_exec: alu_op=%b srca=%b srcb=%b want 010 1 00", alu_op, alu_src_a, alu_src_b);
        end
      end
      if (exp_st[i] == 5) begin
        checks++;
        if ({reg_wr, reg_dst, mem_to_reg} !== 5'b1_11_00) begin
          errs++;
          $display("FAIL sub_wb: wr/dst/m2r=%b want 11100", {reg_wr, reg_dst, mem_to_reg});
        end
      end
    end
  endtask

  task automatic test_lw();
    int exp_st[8];
    exp_st = '{1, 2, 3, 8, 9, 10, 11, 1};
    do_reset(6'h23, 6'h00);
    foreach (exp_st[i]) begin
      step();
      checks++;
      if (state_out !== exp_st[i][4:0]) begin
        errs++;
        $display("FAIL lw_seq[%0d]: state=%0d want %0d", i, state_out, exp_st[i]);
      end
      if (exp_st[i] == 9 || exp_st[i] == 10) begin
        checks++;
        if ({pc_write, mem_wr, ir_wr, reg_wr, alu_op} !== 7'b0) begin
          errs++;
          $display("FAIL lw_wait[%0d]: strobes/op=%b want 0000000", i, {pc_write, mem_wr, ir_wr, reg_wr, alu_op});
        end
      end
      if (exp_st[i] == 11) begin
        checks++;
        if ({reg_wr, reg_dst, mem_to_reg} !== 5'b1_00_01) begin
          errs++;
          $display("FAIL lw_wb: wr/dst/m2r=%b want 10001", {reg_wr, reg_dst, mem_to_reg});
        end
      end
    end
  endtask

  task automatic test_sw();
    int exp_st[6];
    int wr_cycles;
    exp_st = '{1, 2, 3, 8, 12, 1};
    wr_cycles = 0;
    do_reset(6'h2B, 6'h00);
    foreach (exp_st[i]) begin
      step();
      checks++;
      if (state_out !== exp_st[i][4:0]) begin
        errs++;
        $display("FAIL sw_seq[%0d]: state=%0d want %0d", i, state_out, exp_st[i]);
      end
      if (mem_wr === 1'b1) wr_cycles++;
      if (exp_st[i] == 12) begin
        checks++;
        if (mem_wr !== 1'b1 || reg_wr !== 1'b0) begin
          errs++;
          $display("FAIL sw_strobe: mem_wr=%b reg_wr=%b want 1 0", mem_wr, reg_wr);
        end
      end
    end
    checks++;
    if (wr_cycles != 1) begin
      errs++;
      $display("FAIL sw_width: mem_wr cycles=%0d want 1", wr_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset(6'h05, 6'h00);
    zero = 1'b1;
    repeat (4) step();
    checks++;
    if (state_out !== 5'd13 || pc_write !== 1'b0 || alu_op !== 3'b010) begin
      errs++;
      $display("FAIL bne_taken_not: state=%0d pcw=%b op=%b want 13 0 010", state_out, pc_write, alu_op);
    end
    zero = 1'b0;
    #1;
    checks++;
    if (pc_write !== 1'b1 || pc_source !== 2'b01) begin
      errs++;
      $display("FAIL bne_taken: pcw=%b pcsrc=%b want 1 01", pc_write, pc_source);
    end
    step();
    checks++;
    if (state_out !== 5'd1) begin
      errs++;
      $display("FAIL bne_next: state=%0d want 1", state_out);
    end
    do_reset(6'h04, 6'h00);
    zero = 1'b1;
    repeat (4) step();
    checks++;
    if (state_out !== 5'd13 || pc_write !== 1'b1) begin
      errs++;
      $display("FAIL beq_taken: state=%0d pcw=%b want 13 1", state_out, pc_write);
    end
  endtask

  task automatic test_jumps();
    do_reset(6'h03, 6'h00);
    repeat (4) step();
    checks++;
    if (state_out !== 5'd15 || {reg_wr, reg_dst, mem_to_reg, pc_write, pc_source} !== 8'b1_10_10_1_10) begin
      errs++;
      $display("FAIL jal: state=%0d ctl=%b want 15 11010110", state_out,
               {reg_wr, reg_dst, mem_to_reg, pc_write, pc_source});
    end
    do_reset(6'h02, 6'h00);
    repeat (4) step();
    checks++;
    if (state_out !== 5'd14 || {reg_wr, pc_write, pc_source} !== 4'b0_1_10) begin
      errs++;
      $display("FAIL jump: state=%0d ctl=%b want 14 0110", state_out, {reg_wr, pc_write, pc_source});
    end
    do_reset(6'h00, 6'h08);
    repeat (4) step();
    checks++;
    if (state_out !== 5'd16 || {alu_src_a, alu_src_b, alu_op, pc_source, pc_write} !== 9'b1_00_000_00_1) begin
      errs++;
      $display("FAIL jr: state=%0d ctl=%b want 16 100000001", state_out,
               {alu_src_a, alu_src_b, alu_op, pc_source, pc_write});
    end
  endtask

  task automatic test_nop();
    do_reset(6'h3F, 6'h00);
    repeat (3) step();
    checks++;
    if (state_out !== 5'd3 || {reg_wr, mem_wr, pc_write, ir_wr} !== 4'b0) begin
      errs++;
      $display("FAIL nop_decode: state=%0d strobes=%b want 3 0000", state_out, {reg_wr, mem_wr, pc_write, ir_wr});
    end
    step();
    checks++;
    if (state_out !== 5'd1) begin
      errs++;
      $display("FAIL nop_next: state=%0d want 1", state_out);
    end
    do_reset(6'h00, 6'h25);
    repeat (4) step();
    checks++;
    if (state_out !== 5'd1) begin
      errs++;
      $display("FAIL bad_funct: state=%0d want 1", state_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(6'h00, 6'h20);
    repeat (5) step();
    checks++;
    if (state_out !== 5'd5) begin
      errs++;
      $display("FAIL mid_setup_wbr: state=%0d want 5", state_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (state_out !== 5'd0 || {reg_dst, mem_to_reg} !== 4'b01_11) begin
      errs++;
      $display("FAIL mid_reset_wbr: state=%0d dst/m2r=%b want 0 0111", state_out, {reg_dst, mem_to_reg});
    end
    step();
    checks++;
    if (state_out !== 5'd0) begin
      errs++;
      $display("FAIL reset_hold: state=%0d want 0", state_out);
    end
    do_reset(6'h2B, 6'h00);
    repeat (5) step();
    reset = 1'b1;
    step();
    checks++;
    if (state_out !== 5'd0 || mem_wr !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_sw: state=%0d mem_wr=%b want 0 0", state_out, mem_wr);
    end
    reset = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset(6'h00, 6'h20);
    overflow = 1'b1;
    repeat (5) step();
`ifdef CONTROL_UNIT_OVF_EXC_EN
    checks++;
    if (state_out !== 5'd17 || {epc_wr, pc_source, pc_write, reg_wr} !== 5'b1_11_1_0) begin
      errs++;
      $display("FAIL ovf_exc: state=%0d ctl=%b want 17 11110", state_out, {epc_wr, pc_source, pc_write, reg_wr});
    end
    step();
    checks++;
    if (state_out !== 5'd1) begin
      errs++;
      $display("FAIL ovf_next: state=%0d want 1", state_out);
    end
`else
    checks++;
    if (state_out !== 5'd5 || epc_wr !== 1'b0 || reg_wr !== 1'b1) begin
      errs++;
      $display("FAIL ovf_ignored: state=%0d epc=%b wr=%b want 5 0 1", state_out, epc_wr, reg_wr);
    end
`endif
    overflow = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    test_reset();
    test_rtype_sub();
    test_lw();
    test_sw();
    test_branch();
    test_jumps();
    test_nop();
    test_reset_mid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

  always @(negedge clk) begin
    if (reg_wr === 1'b1 && mem_wr === 1'b1) begin
      errs++;
      $display("FAIL wr_exclusive: reg_wr=%b mem_wr=%b want not both 1", reg_wr, mem_wr);
    end
    if (ir_wr === 1'b1 && state_out !== 5'd2) begin
      errs++;
      $display("FAIL ir_wr_state: state=%0d ir_wr=%b want ir_wr only in 2", state_out, ir_wr);
    end
  end
endmodule
